// File: rtl/regfile_ctrl_pkg.sv
// Shared types and sizing constants for the register-file write-port controller,
// also reused by the register file and the hazard unit.
package regfile_ctrl_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    req_idx_t last_q;
    req_idx_t last_d;

    always_comb begin
        gnt    = req;
        last_d = last_q;
        if (req == 2'b11) begin
            gnt = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
        end
        if (advance && (gnt != 2'b00)) begin
            last_d = gnt[1] ? REQ_MEM : REQ_ALU;
        end
    end

    // Resetting to ALU-as-last-winner hands the first tie to the memory path.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_ALU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: post-reset zeroing sweep, ALU/MEM write-back
// arbitration onto the single write port, and the pending-write scoreboard.
module regfile_wb_ctrl #(
    parameter int DATA_W         = 32,
    parameter int NUM_REGS       = regfile_ctrl_pkg::NUM_REGS,
    parameter int ADDR_W         = $clog2(NUM_REGS),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                mark_en,
    input  logic [ADDR_W-1:0]   mark_rd,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                init_done,
    output logic                rf_write_en,
    output logic [ADDR_W-1:0]   rf_a3,
    output logic [DATA_W-1:0]   rf_din
);

    regfile_ctrl_pkg::state_t state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   a3_q, a3_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic                run;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                granted;
    logic [ADDR_W-1:0]   win_rd;
    logic [DATA_W-1:0]   win_data;

    assign run       = (state_q == regfile_ctrl_pkg::RUN);
    assign req       = {mem_valid, alu_valid} & {2{run & ~rst}};
    assign granted   = |gnt;
    assign win_rd    = gnt[1] ? mem_rd : alu_rd;
    assign win_data  = gnt[1] ? mem_data : alu_data;

    assign alu_ready   = gnt[0];
    assign mem_ready   = gnt[1];
    assign init_done   = run;
    assign busy_mask   = busy_q;
    assign rf_write_en = we_q;
    assign rf_a3       = a3_q;
    assign rf_din      = din_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (run),
        .gnt     (gnt)
    );

    // The sweep counter is one bit wider so the cycle after the last register
    // is written can be told apart and used to leave INIT without a write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        a3_d    = a3_q;
        din_d   = din_q;
        busy_d  = busy_q;
        case (state_q)
            regfile_ctrl_pkg::INIT: begin
                if (cnt_q < (ADDR_W+1)'(NUM_REGS)) begin
                    we_d  = 1'b1;
                    a3_d  = cnt_q[ADDR_W-1:0];
                    din_d = '0;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = regfile_ctrl_pkg::RUN;
                end
            end
            regfile_ctrl_pkg::RUN: begin
                if (granted) begin
                    we_d  = (win_rd != '0);
                    a3_d  = win_rd;
                    din_d = win_data;
                    if (win_rd != '0) begin
                        busy_d[win_rd] = 1'b0;
                    end
                end
                // Applied after the clear so a newer producer's mark survives.
                if (mark_en && (mark_rd != '0)) begin
                    busy_d[mark_rd] = 1'b1;
                end
            end
            default: state_d = regfile_ctrl_pkg::RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? regfile_ctrl_pkg::INIT : regfile_ctrl_pkg::RUN;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            a3_q    <= '0;
            din_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            a3_q    <= a3_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-port controller for the 32x32 register file.
- After reset it sweeps every register to zero, because the register file itself only clears x0.
- In normal operation it round-robin arbitrates two write-back requesters (ALU path, memory/load path) onto the single write port (write_en, a3, din).
- It keeps a pending-write scoreboard (busy_mask) so hazard logic can stall on registers with writes in flight.

Parameters:
- DATA_W, 32, data width of write-back values and register file entries
- NUM_REGS, 32, number of architectural registers swept at init
- ADDR_W, 5, register index width; equals clog2(NUM_REGS)
- CLEAR_ON_RESET, 1, 1 = run the zeroing sweep after reset; 0 = enter RUN directly

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU write data
- mem_valid  in  1  memory write-back request
- mem_ready  out  1  memory request accepted this cycle
- mem_rd  in  ADDR_W  memory destination register
- mem_data  in  DATA_W  memory write data
- mark_en  in  1  issue stage marks mark_rd as pending
- mark_rd  in  ADDR_W  register being marked
- busy_mask  out  NUM_REGS  bit i = write to register i pending
- init_done  out  1  high while in RUN
- rf_write_en  out  1  to register file write_en
- rf_a3  out  ADDR_W  to register file a3
- rf_din  out  DATA_W  to register file din

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state = INIT if CLEAR_ON_RESET, else RUN
  - sweep counter = 0
  - rf_write_en, rf_a3, rf_din = 0
  - busy_mask = 0
  - rr pointer = ALU (so MEM wins the first tie)
  - alu_ready, mem_ready = 0 during reset
- init_done = (state == RUN), combinational.
- rf_* outputs are registered: a handshake in cycle N drives the write port in cycle N+1, and the register file updates at the end of N+1.
- INIT state:
  - Each cycle, register {rf_write_en=1, rf_a3=counter, rf_din=0}, then counter++.
  - After registering counter = NUM_REGS-1, move to RUN.
  - Result: rf_write_en is high for exactly NUM_REGS consecutive cycles with a3 = 0..NUM_REGS-1.
  - alu_ready = mem_ready = 0 throughout INIT.
  - mark_en is ignored during INIT.
- RUN state, arbitration (combinational on the valids):
  - Only one valid → that requester gets ready = 1.
  - Both valid → grant goes to the requester not granted last; the rr pointer updates only on a grant.
  - The loser's ready stays 0; it must hold valid, rd and data stable until accepted.
  - At most one grant per cycle.
- Write on grant: register {1, rd, data} of the winner. With no grant, rf_write_en = 0 next cycle.
- x0 handling:
  - A granted request with rd = 0 is accepted (ready = 1) but registers rf_write_en = 0.
  - It does not touch busy_mask.
  - mark_rd = 0 is ignored.
- Scoreboard:
  - A granted write to rd != 0 clears busy_mask[rd] in the same edge that registers the write.
  - mark_en sets busy_mask[mark_rd].
  - Set and clear on the same rd in the same cycle → set wins (a newer producer is pending).
  - Marking an already-busy register leaves it busy.
- Reset mid-operation (rst during INIT or RUN):
  - Any registered write is discarded; rf_write_en = 0 the cycle after rst is sampled.
  - The sweep restarts from 0 and busy_mask clears.
- Width rules: rd is used unmodified; there is no truncation since ADDR_W = clog2(NUM_REGS).

Decomposition:
- Shared package regfile_ctrl_pkg holds:
  - state_t enum {INIT, RUN}
  - req_idx_t enum {REQ_ALU, REQ_MEM}
  - constants NUM_REGS and REG_ADDR_W, which the register file and hazard unit also reuse
- One sub-module: rr_arb2, a 2-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: gnt[1:0] (one-hot or zero).
  - Holds its own pointer flop with synchronous reset.

Test Plan:
- Reset sweep: deassert rst with CLEAR_ON_RESET=1 → rf_write_en high 32 cycles, rf_a3 = 0..31, rf_din = 0; init_done rises on the edge after a3 = 31 is registered; readies 0 throughout.
- Single requester: in RUN, alu_valid=1, rd=5, data=0xDEADBEEF → alu_ready=1 same cycle; next cycle rf_write_en=1, rf_a3=5, rf_din=0xDEADBEEF; with valid low, rf_write_en=0 the following cycle.
- Contention: both valid for 4 cycles (alu rd=3, mem rd=7) with pointer at reset value → grants MEM, ALU, MEM, ALU; the write port shows a3 = 7, 3, 7, 3.
- Scoreboard:
  - mark rd=9 → busy_mask[9]=1 next cycle; a granted mem write to rd=9 clears it.
  - mark rd=9 in the same cycle as a granted write to 9 → busy_mask[9] stays 1.
- x0: alu_valid, rd=0, data=0x1234 → alu_ready=1, rf_write_en stays 0, busy_mask unchanged; mark_rd=0 leaves busy_mask[0]=0.
- Reset mid-op: assert rst in the cycle a write is granted → rf_write_en=0 next cycle, busy_mask=0, and the sweep restarts at a3 = 0 once rst drops.
